burst_addr_gen: RTL and testbench

- Parametrised successor to the single-outstanding AXI address sender used by the memcopy engines.
- Splits a transfer of N data beats into AXI INCR bursts that never cross a 4KB boundary, with optional address wrap within a 2^(12+wrap_len) window.
- Issues bursts back-to-back, up to MAX_OUTSTANDING in flight, with rotating AXI IDs; completion credits come back from the data/response side.
- One instance drives either the AR or the AW channel of an engine.

---
 rtl/burst_addr_gen.sv | 257 +++++++++++++++++++++++++
 tb/tb_burst_addr_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_addr_gen.sv
// Splits a beat-count transfer into 4KB-safe AXI INCR bursts with optional window wrap and credit-limited issue.
// Optional statistics outputs are enabled by defining BURST_ADDR_GEN_STATS_EN.
module burst_addr_gen #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [CNT_WIDTH-1:0]  total_beats,
  input  logic [7:0]            max_len,
  input  logic                  wrap_en,
  input  logic [3:0]            wrap_len,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] axi_addr,
  output logic [7:0]            axi_len,
  output logic [ID_WIDTH-1:0]   axi_id,
  output logic                  axi_valid,
  input  logic                  axi_ready,
  input  logic                  cmpl_valid,
  output logic [7:0]            outstanding,
  output logic                  busy,
  output logic                  done
`ifdef BURST_ADDR_GEN_STATS_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Beats in the next burst: limited by max_len+1, the 4KB page end and the beats still owed.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [CNT_WIDTH-1:0] rem,
                                             input logic [7:0] mlen);
    logic [12:0] btb;
    logic [12:0] lim;
    logic [12:0] cap;
    btb = (13'd4096 - {1'b0, page_off}) >> BEAT_SHIFT;
    lim = {4'd0, ({1'b0, mlen} + 9'd1)};
    cap = (btb < lim) ? btb : lim;
    cap = (rem < CNT_WIDTH'(cap)) ? rem[12:0] : cap;
    return cap[8:0];
  endfunction

  // Address following a burst; when wrapping, the bits above the window come from the job base.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] cur,
                                                      input logic [8:0] beats,
                                                      input logic [ADDR_WIDTH-1:0] base,
                                                      input logic wrap,
                                                      input logic [3:0] wl);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] hi_mask;
    inc     = cur + (ADDR_WIDTH'(beats) << BEAT_SHIFT);
    hi_mask = {ADDR_WIDTH{1'b1}} << (5'd12 + {1'b0, wl});
    return wrap ? ((base & hi_mask) | (inc & ~hi_mask)) : inc;
  endfunction

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] base_addr_r;
  logic [CNT_WIDTH-1:0]  total_r;
  logic [CNT_WIDTH-1:0]  remaining_r;
  logic [7:0]            max_len_r;
  logic                  wrap_en_r;
  logic [3:0]            wrap_len_r;
  logic                  abort_pend_r;
  logic [ADDR_WIDTH-1:0] axi_addr_r;
  logic [7:0]            axi_len_r;
  logic [ID_WIDTH-1:0]   axi_id_r;
  logic                  axi_valid_r;
  logic [7:0]            outstanding_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  hs_s;
  logic                  cmpl_ok_s;
  logic [7:0]            out_nxt_s;
  logic                  credit_ok_s;
  logic [ADDR_WIDTH-1:0] cand_addr_s;
  logic [CNT_WIDTH-1:0]  cand_rem_s;
  logic [8:0]            cand_beats_s;

  // Handshake, credit bookkeeping and the candidate next burst.
  always_comb begin
    hs_s        = axi_valid_r & axi_ready;
    cmpl_ok_s   = cmpl_valid & (outstanding_r != 8'd0);
    out_nxt_s   = outstanding_r;
    cand_addr_s = base_addr_r;
    cand_rem_s  = total_r;
    if (hs_s && !cmpl_ok_s) begin
      out_nxt_s = outstanding_r + 8'd1;
    end else if (!hs_s && cmpl_ok_s) begin
      out_nxt_s = outstanding_r - 8'd1;
    end else begin
      out_nxt_s = outstanding_r;
    end
    credit_ok_s = (out_nxt_s < MAX_OUT);
    if (state_r == ST_CALC) begin
      cand_addr_s = base_addr_r;
      cand_rem_s  = total_r;
    end else begin
      cand_addr_s = next_addr(axi_addr_r, {1'b0, axi_len_r} + 9'd1, base_addr_r,
                              wrap_en_r, wrap_len_r);
      cand_rem_s  = remaining_r;
    end
    cand_beats_s = burst_beats(cand_addr_s[11:0], cand_rem_s, max_len_r);
  end

  // Control FSM with registered AXI address outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      base_addr_r   <= {ADDR_WIDTH{1'b0}};
      total_r       <= {CNT_WIDTH{1'b0}};
      remaining_r   <= {CNT_WIDTH{1'b0}};
      max_len_r     <= 8'd0;
      wrap_en_r     <= 1'b0;
      wrap_len_r    <= 4'd0;
      abort_pend_r  <= 1'b0;
      axi_addr_r    <= {ADDR_WIDTH{1'b0}};
      axi_len_r     <= 8'd0;
      axi_id_r      <= {ID_WIDTH{1'b0}};
      axi_valid_r   <= 1'b0;
      outstanding_r <= 8'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      outstanding_r <= out_nxt_s;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_addr_r  <= src_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
            total_r      <= total_beats;
            max_len_r    <= max_len;
            wrap_en_r    <= wrap_en;
            wrap_len_r   <= wrap_len;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (total_r == {CNT_WIDTH{1'b0}}) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (abort) begin
            state_r <= ST_DRAIN;
          end else begin
            axi_addr_r  <= cand_addr_s;
            axi_len_r   <= 8'(cand_beats_s - 9'd1);
            remaining_r <= cand_rem_s - CNT_WIDTH'(cand_beats_s);
            axi_valid_r <= credit_ok_s;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hs_s) begin
            axi_id_r <= axi_id_r + {{(ID_WIDTH-1){1'b0}}, 1'b1};
            if ((remaining_r == {CNT_WIDTH{1'b0}}) || abort || abort_pend_r) begin
              axi_valid_r <= 1'b0;
              state_r     <= ST_DRAIN;
            end else begin
              axi_addr_r  <= cand_addr_s;
              axi_len_r   <= 8'(cand_beats_s - 9'd1);
              remaining_r <= cand_rem_s - CNT_WIDTH'(cand_beats_s);
              axi_valid_r <= credit_ok_s;
            end
          end else if (axi_valid_r) begin
            // A presented burst must complete; remember the abort for after it.
            abort_pend_r <= abort_pend_r | abort;
          end else if (abort || abort_pend_r) begin
            state_r <= ST_DRAIN;
          end else begin
            axi_valid_r <= credit_ok_s;
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == 8'd0) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          axi_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi_addr    = axi_addr_r;
  assign axi_len     = axi_len_r;
  assign axi_id      = axi_id_r;
  assign axi_valid   = axi_valid_r;
  assign outstanding = outstanding_r;
  assign busy        = busy_r;
  assign done        = done_r;

`ifdef BURST_ADDR_GEN_STATS_EN
  logic [31:0] stat_bursts_r;
  logic [31:0] stat_stall_r;

  // Saturating job statistics, cleared when a job is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_bursts_r <= 32'd0;
      stat_stall_r  <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      stat_bursts_r <= 32'd0;
      stat_stall_r  <= 32'd0;
    end else begin
      if (hs_s && (stat_bursts_r != 32'hFFFF_FFFF)) begin
        stat_bursts_r <= stat_bursts_r + 32'd1;
      end else begin
        stat_bursts_r <= stat_bursts_r;
      end
      if ((state_r == ST_ISSUE) && (stat_stall_r != 32'hFFFF_FFFF) &&
          ((axi_valid_r && !axi_ready) || (!axi_valid_r && (outstanding_r >= MAX_OUT)))) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end else begin
        stat_stall_r <= stat_stall_r;
      end
    end
  end

  assign stat_bursts       = stat_bursts_r;
  assign stat_stall_cycles = stat_stall_r;
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed bench for burst_addr_gen (512-bit data, two credits) with hand-computed burst expectations.
module tb_burst_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] src_addr;
  logic [39:0] total_beats;
  logic [7:0]  max_len;
  logic        wrap_en;
  logic [3:0]  wrap_len;
  logic        abort;
  logic [63:0] axi_addr;
  logic [7:0]  axi_len;
  logic [1:0]  axi_id;
  logic        axi_valid;
  logic        axi_ready;
  logic        cmpl_valid;
  logic [7:0]  outstanding;
  logic        busy;
  logic        done;
`ifdef BURST_ADDR_GEN_STATS_EN
  logic [31:0] stat_bursts;
  logic [31:0] stat_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  burst_addr_gen #(
    .ADDR_WIDTH(64), .DATA_WIDTH(512), .ID_WIDTH(2), .MAX_OUTSTANDING(2), .CNT_WIDTH(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .total_beats(total_beats), .max_len(max_len), .wrap_en(wrap_en),
    .wrap_len(wrap_len), .abort(abort), .axi_addr(axi_addr), .axi_len(axi_len),
    .axi_id(axi_id), .axi_valid(axi_valid), .axi_ready(axi_ready),
    .cmpl_valid(cmpl_valid), .outstanding(outstanding), .busy(busy), .done(done)
`ifdef BURST_ADDR_GEN_STATS_EN
    , .stat_bursts(stat_bursts), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [63:0] a, input logic [39:0] n, input logic [7:0] ml,
                           input logic we, input logic [3:0] wl);
    src_addr = a; total_beats = n; max_len = ml; wrap_en = we; wrap_len = wl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (axi_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 64'(axi_valid), 64'd1);
  endtask

  task automatic expect_burst(input string tag, input logic [63:0] a, input logic [7:0] l,
                              input logic [1:0] id);
    wait_valid(tag);
    check({tag, " addr"}, axi_addr, a);
    check({tag, " len"}, 64'(axi_len), 64'(l));
    check({tag, " id"}, 64'(axi_id), 64'(id));
    axi_ready = 1'b1;
    tick();
    axi_ready = 1'b0;
  endtask

  task automatic cmpl_pulse();
    cmpl_valid = 1'b1;
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " outstanding"}, 64'(outstanding), 64'd0);
    tick();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = 64'd0; total_beats = 40'd0; max_len = 8'd0;
    wrap_en = 1'b0; wrap_len = 4'd0; abort = 1'b0; axi_ready = 1'b0; cmpl_valid = 1'b0;
    tick();
    tick();
    check("rst valid", 64'(axi_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst outstanding", 64'(outstanding), 64'd0);
    check("rst id", 64'(axi_id), 64'd0);
    rst_n = 1'b1;
    tick();

    // Four 2KB bursts, one completion after each.
    start_job(64'h1000, 40'd128, 8'd31, 1'b0, 4'd0);
    expect_burst("t1 b0", 64'h1000, 8'd31, 2'd0);
    cmpl_pulse();
    expect_burst("t1 b1", 64'h1800, 8'd31, 2'd1);
    cmpl_pulse();
    expect_burst("t1 b2", 64'h2000, 8'd31, 2'd2);
    cmpl_pulse();
    expect_burst("t1 b3", 64'h2800, 8'd31, 2'd3);
    check("t1 no more valid", 64'(axi_valid), 64'd0);
    check("t1 busy drain", 64'(busy), 64'd1);
    check("t1 one in flight", 64'(outstanding), 64'd1);
    cmpl_pulse();
    wait_done("t1");

    // Two beats to the 4KB page end, then the remaining eight.
    start_job(64'h1F80, 40'd10, 8'd15, 1'b0, 4'd0);
    expect_burst("t2 b0", 64'h1F80, 8'd1, 2'd0);
    expect_burst("t2 b1", 64'h2000, 8'd7, 2'd1);
    check("t2 two in flight", 64'(outstanding), 64'd2);
    cmpl_pulse();
    cmpl_pulse();
    wait_done("t2");

    // Credit limit of two holds the third burst until a completion returns.
    start_job(64'h3000, 40'd96, 8'd31, 1'b0, 4'd0);
    expect_burst("t3 b0", 64'h3000, 8'd31, 2'd2);
    expect_burst("t3 b1", 64'h3800, 8'd31, 2'd3);
    tick();
    tick();
    tick();
    check("t3 credit stall", 64'(axi_valid), 64'd0);
    check("t3 credits used", 64'(outstanding), 64'd2);
    cmpl_pulse();
    expect_burst("t3 b2", 64'h4000, 8'd31, 2'd0);
    cmpl_pulse();
    cmpl_pulse();
    wait_done("t3");

    // 4KB wrap window: the second burst returns to the window base.
    start_job(64'h5000, 40'd128, 8'd63, 1'b1, 4'd0);
    expect_burst("t4 b0", 64'h5000, 8'd63, 2'd1);
    cmpl_pulse();
    expect_burst("t4 b1", 64'h5000, 8'd63, 2'd2);
    cmpl_pulse();
    wait_done("t4");

    // Abort while a burst is stalled: it must stay presented and stable.
    start_job(64'h8000, 40'd128, 8'd31, 1'b0, 4'd0);
    wait_valid("t5");
    check("t5 addr", axi_addr, 64'h8000);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 valid held", 64'(axi_valid), 64'd1);
      check("t5 addr stable", axi_addr, 64'h8000);
      check("t5 len stable", 64'(axi_len), 64'd31);
      check("t5 id stable", 64'(axi_id), 64'd3);
    end
    abort = 1'b0;
    axi_ready = 1'b1;
    tick();
    axi_ready = 1'b0;
    check("t5 valid after abort", 64'(axi_valid), 64'd0);
    tick();
    tick();
    check("t5 still no valid", 64'(axi_valid), 64'd0);
    check("t5 draining", 64'(busy), 64'd1);
    cmpl_pulse();
    wait_done("t5");

    // Abort during CALC: no burst, straight to drain and done.
    abort = 1'b1;
    start_job(64'h9000, 40'd64, 8'd31, 1'b0, 4'd0);
    tick();
    abort = 1'b0;
    check("t6 no valid", 64'(axi_valid), 64'd0);
    tick();
    check("t6 done", 64'(done), 64'd1);
    check("t6 no valid at done", 64'(axi_valid), 64'd0);
    tick();

    // Zero-length job: done two cycles after start.
    start_job(64'hA000, 40'd0, 8'd31, 1'b0, 4'd0);
    check("t7 calc busy", 64'(busy), 64'd1);
    check("t7 calc no done", 64'(done), 64'd0);
    tick();
    check("t7 done", 64'(done), 64'd1);
    check("t7 no valid", 64'(axi_valid), 64'd0);
    tick();
    check("t7 done pulse", 64'(done), 64'd0);
    check("t7 idle", 64'(busy), 64'd0);

    // Reset in the middle of ISSUE clears everything.
    start_job(64'h0, 40'd128, 8'd31, 1'b0, 4'd0);
    expect_burst("t8 b0", 64'h0, 8'd31, 2'd0);
    check("t8 next valid", 64'(axi_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check("t8 rst valid", 64'(axi_valid), 64'd0);
    check("t8 rst addr", axi_addr, 64'd0);
    check("t8 rst len", 64'(axi_len), 64'd0);
    check("t8 rst id", 64'(axi_id), 64'd0);
    check("t8 rst outstanding", 64'(outstanding), 64'd0);
    check("t8 rst busy", 64'(busy), 64'd0);
    check("t8 rst done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
